// File: rtl/cache_stage.sv
// Direct-mapped, write-through/no-allocate cache stage between TLB lookup and writeback.
// Optional macro CACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module cache_stage #(
  parameter int NUM_LINES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_cache,
  input  logic [15:0] tlblookup_result,
  input  logic [2:0]  destReg_addr_input,
  input  logic        we_input,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [15:0] store_data,
  output logic [15:0] cache_result,
  output logic [2:0]  destReg_addr_output,
  output logic        we_output,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 14 - IW;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_t;

  state_t                 r_state;
  logic [NUM_LINES-1:0]   r_valid;
  logic [TW-1:0]          r_tag  [NUM_LINES];
  logic [63:0]            r_line [NUM_LINES];
  logic [15:0]            r_result;
  logic [2:0]             r_dest;
  logic                   r_we;
  logic                   r_mem_req;
  logic                   r_mem_we;
  logic [15:0]            r_mem_addr;
  logic [15:0]            r_mem_wdata;

  logic [IW-1:0]  w_idx;
  logic [TW-1:0]  w_tag;
  logic [1:0]     w_off;
  logic           w_st;
  logic           w_ld;
  logic           w_hit;
  logic [15:0]    w_hit_word;
  logic [15:0]    w_fill_word;
  logic           w_stall;

  assign w_idx       = tlblookup_result[IW+1:2];
  assign w_tag       = tlblookup_result[15:IW+2];
  assign w_off       = tlblookup_result[1:0];
  assign w_st        = is_store;
  assign w_ld        = is_load & ~is_store;
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_hit_word  = r_line[w_idx][{w_off, 4'b0000} +: 16];
  assign w_fill_word = mem_rdata[{w_off, 4'b0000} +: 16];

  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      S_IDLE:  w_stall = w_st | (w_ld & ~w_hit);
      S_FILL,
      S_WRITE: w_stall = ~mem_ack;
      default: w_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_result    <= '0;
      r_dest      <= '0;
      r_we        <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (enable_cache) begin
      case (r_state)
        S_IDLE: begin
          r_dest <= destReg_addr_input;
          if (w_st) begin
            r_state     <= S_WRITE;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= tlblookup_result;
            r_mem_wdata <= store_data;
            r_we        <= 1'b0;
          end else if (w_ld && !w_hit) begin
            r_state    <= S_FILL;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {tlblookup_result[15:2], 2'b00};
            r_we       <= 1'b0;
          end else begin
            r_result <= w_ld ? w_hit_word : tlblookup_result;
            r_we     <= we_input;
          end
        end
        S_FILL: begin
          r_dest <= destReg_addr_input;
          if (mem_ack) begin
            r_valid[w_idx] <= 1'b1;
            r_result       <= w_fill_word;
            r_we           <= we_input;
            r_mem_req      <= 1'b0;
            r_state        <= S_IDLE;
          end else begin
            r_we <= 1'b0;
          end
        end
        S_WRITE: begin
          r_dest <= destReg_addr_input;
          r_we   <= 1'b0;
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag and data arrays need no reset: the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (!reset && enable_cache && mem_ack) begin
      if (r_state == S_FILL) begin
        r_tag[w_idx]  <= w_tag;
        r_line[w_idx] <= mem_rdata;
      end else if (r_state == S_WRITE && w_hit) begin
        r_line[w_idx][{w_off, 4'b0000} +: 16] <= store_data;
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (enable_cache && r_state == S_IDLE && w_ld) begin
      if (w_hit && r_hit_count != 16'hFFFF)
        r_hit_count <= r_hit_count + 16'd1;
      if (!w_hit && r_miss_count != 16'hFFFF)
        r_miss_count <= r_miss_count + 16'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

  assign stall               = w_stall;
  assign cache_result        = r_result;
  assign destReg_addr_output = r_dest;
  assign we_output           = r_we;
  assign mem_req             = r_mem_req;
  assign mem_we              = r_mem_we;
  assign mem_addr            = r_mem_addr;
  assign mem_wdata           = r_mem_wdata;

endmodule

// File: doc/cache_stage.md
CACHE_STAGE -- requirements
Module: cache_stage

Interface
REQ-001 Parameter: NUM_LINES, 4, number of direct-mapped lines; power of 2 in the range 2..16; IW = log2(NUM_LINES).
REQ-002 Port: clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 Port: reset, input, 1, synchronous, active-high.
REQ-004 Port: enable_cache, input, 1, when 0 the output register and FSM hold.
REQ-005 Port: tlblookup_result, input, 16, address for memory ops or pass-through value for other ops.
REQ-006 Port: destReg_addr_input, input, 3, destination register.
REQ-007 Port: we_input, input, 1, register write enable.
REQ-008 Port: is_load / is_store, input, 1 each, memory op type.
REQ-009 Port: store_data, input, 16, store value.
REQ-010 Port: cache_result / destReg_addr_output / we_output, output, 16/3/1, registered toward wb_stage.
REQ-011 Port: stall, output, 1, combinational; upstream holds all inputs while it is 1.
REQ-012 Port: mem_req, mem_we, output, 1 each; mem_addr, output, 16; mem_wdata, output, 16.
REQ-013 Port: mem_rdata, input, 64; mem_ack, input, 1.

Function
REQ-014 Address split SHALL be: word offset = addr[1:0]; index = addr[IW+1:2]; tag = the remaining upper bits.
REQ-015 Line word i SHALL be mem_rdata[16i+15:16i].
REQ-016 The FSM SHALL have states IDLE, FILL and WRITE; reset state is IDLE.
REQ-017 Non-memory op in IDLE: stall=0; next edge cache_result=tlblookup_result, destReg_addr_output=destReg_addr_input, we_output=we_input (1-cycle latency).
REQ-018 Load hit (valid and tag match) in IDLE: stall=0; next edge cache_result = the cached word; dest and we pass through.
REQ-019 Load miss in IDLE: stall=1; go to FILL; mem_req=1, mem_we=0, mem_addr={addr[15:2],2'b00}.
REQ-020 In FILL: stall=!mem_ack; mem_req and mem_addr held stable.
REQ-021 On mem_ack in FILL: the line SHALL be written, its tag set and valid set; the output register captures the requested word from mem_rdata; state returns to IDLE.
REQ-022 Store in IDLE (write-through, no-allocate): stall=1; go to WRITE; mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=store_data.
REQ-023 In WRITE: stall=!mem_ack.
REQ-024 On mem_ack in WRITE: on a hit, update the cached word; output we_output=0; state returns to IDLE.
REQ-025 While stall=1, the output register SHALL load a bubble (we_output=0).
REQ-026 If is_load and is_store are both 1, the op SHALL be treated as a store.
REQ-027 mem_ack in IDLE SHALL be ignored.
REQ-028 mem_req SHALL deassert on the edge after ack.
REQ-029 enable_cache=0 SHALL freeze all state, but mem_req stays asserted if already pending.

Reset
REQ-030 On reset: state=IDLE; all valid bits cleared; cache_result=0, destReg_addr_output=0, we_output=0, mem_req=0, mem_we=0.
REQ-031 Reset during FILL or WRITE SHALL abort the transaction; mem_req is low the next cycle and no line is updated.

Configuration
REQ-032 Macro CACHE_STATS_EN: when defined, outputs hit_count[15:0] and miss_count[15:0] are present.
REQ-033 With CACHE_STATS_EN defined: hit_count increments on each non-stalled load hit; miss_count increments on each IDLE->FILL transition; both saturate at 16'hFFFF and clear on reset.
REQ-034 Without CACHE_STATS_EN: the counters and their ports are absent and behaviour is otherwise identical.

Verification
REQ-035 Pass-through: reset, then non-memory op with value 16'h1234, dest 3, we 1 -> next cycle cache_result=16'h1234, dest=3, we=1, stall=0.
REQ-036 Load miss: load 16'h0045 -> stall=1, mem_req=1, mem_addr=16'h0044; ack after 3 cycles with mem_rdata=64'h4444_3333_2222_1111 -> stall low in the ack cycle, then cache_result=16'h2222.
REQ-037 Load hit: load 16'h0046 after REQ-036 -> mem_req stays 0, next cycle cache_result=16'h3333.
REQ-038 Store then load: store 16'hBEEF to 16'h0047 -> mem_we=1, mem_addr=16'h0047, mem_wdata=16'hBEEF; after ack, load 16'h0047 hits and returns 16'hBEEF.
REQ-039 Conflict (NUM_LINES=4): load 16'h0085 (same index, new tag) -> miss and refill; a following load of 16'h0045 misses.
REQ-040 Reset during FILL: mem_req=0 the next cycle; a subsequent load of 16'h0046 misses.
